// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO completer front-end: register map, FSM states
// and the address-legality helper.
package apb_gpio_pkg;

  localparam logic [31:0] RGPIO_IN    = 32'h0000_0000;
  localparam logic [31:0] RGPIO_OUT   = 32'h0000_0004;
  localparam logic [31:0] RGPIO_OE    = 32'h0000_0008;
  localparam logic [31:0] RGPIO_INTE  = 32'h0000_000C;
  localparam logic [31:0] RGPIO_PTRIG = 32'h0000_0010;
  localparam logic [31:0] RGPIO_AUX   = 32'h0000_0014;
  localparam logic [31:0] RGPIO_CTRL  = 32'h0000_0018;
  localparam logic [31:0] RGPIO_INTS  = 32'h0000_001C;
  localparam logic [31:0] RGPIO_ECLK  = 32'h0000_0020;
  localparam logic [31:0] RGPIO_NEC   = 32'h0000_0024;

  localparam logic [31:0] LAST_ADDR   = RGPIO_NEC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACC  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACC  = 2'd3
  } apb_state_e;

  // Word-aligned and not beyond the last implemented register.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] last);
    return (addr <= last) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_gpio_slave_if.sv
// APB3 completer front-end for the GPIO register block (writes 0 wait states, reads 1).
// Optional privilege check on writes is enabled by defining APB_GPIO_PPROT_EN.
module apb_gpio_slave_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] LAST_ADDR = apb_gpio_pkg::LAST_ADDR
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
`ifdef APB_GPIO_PPROT_EN
  input  logic [2:0]        pprot,
`endif
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              gpio_we,
  output logic [ADDR_W-1:0] gpio_addr,
  output logic [31:0]       gpio_dat_i,
  input  logic [31:0]       gpio_dat_o
);

  import apb_gpio_pkg::*;

  apb_state_e        state_r, state_nxt_s;
  logic              pready_r, pready_nxt_s;
  logic              pslverr_r, pslverr_nxt_s;
  logic              gpio_we_r, gpio_we_nxt_s;
  logic [ADDR_W-1:0] gpio_addr_r, gpio_addr_nxt_s;
  logic [31:0]       gpio_dat_i_r, gpio_dat_i_nxt_s;
  logic              legal_r, legal_nxt_s;
  logic              legal_s;
  logic              wr_ok_s;

  assign legal_s = addr_legal(64'(paddr), 64'(LAST_ADDR));

`ifdef APB_GPIO_PPROT_EN
  logic unused_pprot_s;
  assign unused_pprot_s = ^pprot[2:1];
  // Unprivileged writes are refused but still complete with an error.
  assign wr_ok_s = legal_s & pprot[0];
`else
  assign wr_ok_s = legal_s;
`endif

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_nxt_s      = state_r;
    pready_nxt_s     = 1'b0;
    pslverr_nxt_s    = 1'b0;
    gpio_we_nxt_s    = 1'b0;
    gpio_addr_nxt_s  = gpio_addr_r;
    gpio_dat_i_nxt_s = gpio_dat_i_r;
    legal_nxt_s      = legal_r;
    case (state_r)
      IDLE: begin
        if (psel && !penable) begin
          gpio_addr_nxt_s = paddr;
          legal_nxt_s     = legal_s;
          if (pwrite) begin
            gpio_dat_i_nxt_s = pwdata;
            gpio_we_nxt_s    = wr_ok_s;
            pready_nxt_s     = 1'b1;
            pslverr_nxt_s    = ~wr_ok_s;
            state_nxt_s      = WR_ACC;
          end else begin
            state_nxt_s      = RD_WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_ACC: begin
        state_nxt_s = IDLE;
      end
      RD_WAIT: begin
        if (psel) begin
          pready_nxt_s  = 1'b1;
          pslverr_nxt_s = ~legal_r;
          state_nxt_s   = RD_ACC;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      RD_ACC: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset kills any pending strobe.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r      <= IDLE;
      pready_r     <= 1'b0;
      pslverr_r    <= 1'b0;
      gpio_we_r    <= 1'b0;
      gpio_addr_r  <= '0;
      gpio_dat_i_r <= 32'h0000_0000;
      legal_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pready_r     <= pready_nxt_s;
      pslverr_r    <= pslverr_nxt_s;
      gpio_we_r    <= gpio_we_nxt_s;
      gpio_addr_r  <= gpio_addr_nxt_s;
      gpio_dat_i_r <= gpio_dat_i_nxt_s;
      legal_r      <= legal_nxt_s;
    end
  end

  assign pready     = pready_r;
  assign pslverr    = pslverr_r;
  assign gpio_we    = gpio_we_r;
  assign gpio_addr  = gpio_addr_r;
  assign gpio_dat_i = gpio_dat_i_r;
  // gpio_dat_o is already registered by the register block, so it is only gated here.
  assign prdata     = ((state_r == RD_ACC) && legal_r) ? gpio_dat_o : 32'h0000_0000;

endmodule

// File: tb/tb_apb_gpio_slave_if.sv
// Scoreboard bench for apb_gpio_slave_if with a behavioural GPIO register block.
// Define APB_GPIO_PPROT_EN to include the privilege-check scenario.
module tb_apb_gpio_slave_if;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
`ifdef APB_GPIO_PPROT_EN
  logic [2:0]  pprot = 3'b001;
`endif
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        gpio_we;
  logic [31:0] gpio_addr;
  logic [31:0] gpio_dat_i;
  logic [31:0] gpio_dat_o = 32'h0;

  int errors = 0;
  int checks = 0;
  int wait_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } rsp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [31:0] mem [0:15];

  apb_gpio_slave_if dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
`ifdef APB_GPIO_PPROT_EN
    .pprot      (pprot),
`endif
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .gpio_we    (gpio_we),
    .gpio_addr  (gpio_addr),
    .gpio_dat_i (gpio_dat_i),
    .gpio_dat_o (gpio_dat_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register block model: captures writes and returns registered read data.
  always @(posedge sys_clk) begin
    if (gpio_we) mem[gpio_addr[5:2]] <= gpio_dat_i;
    gpio_dat_o <= mem[gpio_addr[5:2]];
  end

  // Monitor: pops expected strobes and completions whenever the DUT presents them.
  always @(negedge sys_clk) begin
    if (gpio_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_gpio_we", 64'(gpio_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("we_addr", 64'(gpio_addr), 64'(w.addr));
        chk("we_data", 64'(gpio_dat_i), 64'(w.data));
      end
    end
    if (psel && penable) begin
      if (pready) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_completion", 64'(paddr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk({r.name, "_prdata"}, 64'(prdata), 64'(r.rdata));
          chk({r.name, "_pslverr"}, 64'(pslverr), 64'(r.err));
          chk({r.name, "_waits"}, 64'(wait_cnt), 64'(r.waits));
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Entered and left at posedge+1; leaves the bus idle-able for back-to-back use.
  task automatic apb(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err, input logic exp_strobe);
    rsp_t r;
    wr_t  w;
    bit   done;
    r.name  = name;
    r.rdata = exp_rd;
    r.err   = exp_err;
    r.waits = wr ? 0 : 1;
    rsp_q.push_back(r);
    if (exp_strobe) begin
      w.addr = addr;
      w.data = wdata;
      wr_q.push_back(w);
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge sys_clk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge sys_clk);
      if (pready) done = 1'b1;
    end
    if (!done) chk({name, "_timeout"}, 64'd0, 64'd1);
    @(posedge sys_clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prdata"}, 64'(prdata), 64'd0);
    chk({tag, "_pready"}, 64'(pready), 64'd0);
    chk({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    chk({tag, "_gpio_we"}, 64'(gpio_we), 64'd0);
    chk({tag, "_gpio_addr"}, 64'(gpio_addr), 64'd0);
    chk({tag, "_gpio_dat_i"}, 64'(gpio_dat_i), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #12;
    chk_reset_outputs("reset");
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    idle(2);

    // Basic write then read back.
    apb("wr04", 1'b1, 32'h04, 32'hA5A5_0F0F, 32'h0, 1'b0, 1'b1);
    idle(1);
    apb("rd04", 1'b0, 32'h04, 32'h0, 32'hA5A5_0F0F, 1'b0, 1'b0);
    idle(1);

    // Illegal addresses: beyond range and misaligned.
    apb("wr28", 1'b1, 32'h28, 32'h1111_2222, 32'h0, 1'b1, 1'b0);
    apb("wr06", 1'b1, 32'h06, 32'h3333_4444, 32'h0, 1'b1, 1'b0);
    apb("rd28", 1'b0, 32'h28, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1);

    // Back-to-back write then read, plus the highest legal offset.
    apb("wr08", 1'b1, 32'h08, 32'h0000_00FF, 32'h0, 1'b0, 1'b1);
    apb("rd08", 1'b0, 32'h08, 32'h0, 32'h0000_00FF, 1'b0, 1'b0);
    apb("wr24", 1'b1, 32'h24, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    apb("rd24", 1'b0, 32'h24, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    apb("rd0c", 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Abort: psel dropped while the read is waiting.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
    @(posedge sys_clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort_pready", 64'(pready), 64'd0);
    chk("abort_gpio_we", 64'(gpio_we), 64'd0);
    @(posedge sys_clk); #1;
    chk("abort_pready_late", 64'(pready), 64'd0);
    apb("rd04_after_abort", 1'b0, 32'h04, 32'h0, 32'hA5A5_0F0F, 1'b0, 1'b0);
    idle(1);

    // Reset pulsed while the write strobe is high: the strobe must not land.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hDEAD_BEEF;
    @(posedge sys_clk); #1;
    chk("wracc_gpio_we", 64'(gpio_we), 64'd1);
    chk("wracc_pready", 64'(pready), 64'd1);
    psel = 1'b0; sys_rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk_reset_outputs("midreset_held");
    sys_rst = 1'b1;
    idle(2);
    apb("rd10_after_reset", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1);

`ifdef APB_GPIO_PPROT_EN
    // Unprivileged write is refused; the register keeps its old contents.
    pprot = 3'b000;
    apb("wr04_unpriv", 1'b1, 32'h04, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
    pprot = 3'b001;
    apb("rd04_after_unpriv", 1'b0, 32'h04, 32'h0, 32'hA5A5_0F0F, 1'b0, 1'b0);
    idle(1);
`endif

    idle(3);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
